// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect selection and an I-cache miss FSM
// that can abandon or defer redirects while a miss is outstanding.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             PCSrcD,
    input  logic             JumpD,
    input  logic             JumpRegD,
    input  logic [31:0]      BranchTargetD,
    input  logic [31:0]      JumpTargetD,
    input  logic [31:0]      JumpRegTargetD,
    input  logic             Ihit,
    input  logic [31:0]      imem_rdata,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    output logic [31:0]      PCF,
    output logic [31:0]      PCPlus4F,
    output logic [31:0]      InstrF,
    output logic             ValidF,
    output logic             FetchBusy,
    output logic [CNT_W-1:0] MissCount
);

    typedef enum logic [1:0] {StRun, StMiss, StDiscard} state_e;

    state_e             r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_redir;
    logic [CNT_W-1:0]   r_miss_cnt;

    logic               w_redir_valid;
    logic [31:0]        w_redir_tgt;
    logic [31:0]        w_pc_plus4;
    logic [31:0]        w_pc_seq;
    logic               w_valid;

    // A stalled fetch cannot accept a redirect; decode will present it again.
    assign w_redir_valid = !StallF && (JumpRegD || JumpD || PCSrcD);
    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_pc_seq      = StallF ? r_pc : w_pc_plus4;

    always_comb begin
        w_redir_tgt = BranchTargetD;
        if (JumpRegD) begin
            w_redir_tgt = JumpRegTargetD;
        end else if (JumpD) begin
            w_redir_tgt = JumpTargetD;
        end
    end

    // A hit in MISS alongside a redirect returns a word from the wrong path.
    assign w_valid = !reset && Ihit &&
                     ((r_state == StRun) || (r_state == StMiss && !w_redir_valid));

    assign imem_req  = !reset;
    assign imem_addr = r_pc;
    assign PCF       = r_pc;
    assign PCPlus4F  = w_pc_plus4;
    assign ValidF    = w_valid;
    assign InstrF    = w_valid ? imem_rdata : 32'h0;
    assign FetchBusy = !reset && (r_state != StRun);
    assign MissCount = r_miss_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StRun;
            r_pc       <= RESET_PC;
            r_redir    <= 32'h0;
            r_miss_cnt <= '0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (w_redir_valid) begin
                        r_pc <= w_redir_tgt;
                    end else if (Ihit) begin
                        r_pc <= w_pc_seq;
                    end else begin
                        r_state <= StMiss;
                        if (r_miss_cnt != '1) begin
                            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                        end
                    end
                end
                StMiss: begin
                    if (w_redir_valid) begin
                        if (Ihit) begin
                            r_pc    <= w_redir_tgt;
                            r_state <= StRun;
                        end else begin
                            r_redir <= w_redir_tgt;
                            r_state <= StDiscard;
                        end
                    end else if (Ihit) begin
                        r_pc    <= w_pc_seq;
                        r_state <= StRun;
                    end
                end
                StDiscard: begin
                    if (Ihit) begin
                        r_pc    <= w_redir_valid ? w_redir_tgt : r_redir;
                        r_state <= StRun;
                    end else if (w_redir_valid) begin
                        r_redir <= w_redir_tgt;
                    end
                end
                default: begin
                    r_state <= StRun;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, hit streaming, misses, stalls, redirects.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, PCSrcD, JumpD, JumpRegD, Ihit;
    logic [31:0] BranchTargetD, JumpTargetD, JumpRegTargetD, imem_rdata;
    logic        imem_req, ValidF, FetchBusy;
    logic [31:0] imem_addr, PCF, PCPlus4F, InstrF;
    logic [15:0] MissCount;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .StallF         (StallF),
        .PCSrcD         (PCSrcD),
        .JumpD          (JumpD),
        .JumpRegD       (JumpRegD),
        .BranchTargetD  (BranchTargetD),
        .JumpTargetD    (JumpTargetD),
        .JumpRegTargetD (JumpRegTargetD),
        .Ihit           (Ihit),
        .imem_rdata     (imem_rdata),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .PCF            (PCF),
        .PCPlus4F       (PCPlus4F),
        .InstrF         (InstrF),
        .ValidF         (ValidF),
        .FetchBusy      (FetchBusy),
        .MissCount      (MissCount)
    );

    // Memory model: each word is a fixed scramble of its address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_rdata = word_at(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_redir();
        PCSrcD = 0; JumpD = 0; JumpRegD = 0;
    endtask

    initial begin
        reset = 1; StallF = 0; Ihit = 1;
        PCSrcD = 0; JumpD = 1; JumpRegD = 0;
        BranchTargetD = 32'h0; JumpTargetD = 32'h999; JumpRegTargetD = 32'h0;
        #1;
        chk("rst_req", {31'b0, imem_req}, 0);
        chk("rst_valid", {31'b0, ValidF}, 0);
        chk("rst_instr", InstrF, 0);
        chk("rst_busy", {31'b0, FetchBusy}, 0);
        tick(); tick();
        chk("rst_pc", PCF, 32'h0);
        chk("rst_cnt", {16'b0, MissCount}, 0);

        // Hit streaming from reset
        reset = 0; clr_redir();
        #1;
        chk("req_on", {31'b0, imem_req}, 1);
        for (int i = 0; i < 4; i++) begin
            chk("stream_pc", PCF, 32'(4 * i));
            chk("stream_addr", imem_addr, 32'(4 * i));
            chk("stream_valid", {31'b0, ValidF}, 1);
            chk("stream_instr", InstrF, word_at(32'(4 * i)));
            tick();
        end
        chk("stream_cnt", {16'b0, MissCount}, 0);

        // Three-cycle miss at 0x10
        Ihit = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("miss_valid", {31'b0, ValidF}, 0);
            chk("miss_instr", InstrF, 0);
            chk("miss_pc", PCF, 32'h10);
            tick();
            chk("miss_busy", {31'b0, FetchBusy}, 1);
        end
        Ihit = 1;
        #1;
        chk("fill_valid", {31'b0, ValidF}, 1);
        chk("fill_instr", InstrF, word_at(32'h10));
        chk("fill_cnt", {16'b0, MissCount}, 1);
        tick();
        chk("fill_pc", PCF, 32'h14);
        chk("fill_busy", {31'b0, FetchBusy}, 0);
        tick(); tick(); tick();
        chk("at_20", PCF, 32'h20);

        // Stall blocks a branch redirect
        StallF = 1; PCSrcD = 1; BranchTargetD = 32'h100;
        tick();
        chk("stall_pc1", PCF, 32'h20);
        tick();
        chk("stall_pc2", PCF, 32'h20);
        StallF = 0;
        tick();
        chk("branch_pc", PCF, 32'h100);
        clr_redir();
        JumpD = 1; JumpTargetD = 32'h40;
        tick();
        chk("jump_40", PCF, 32'h40);
        clr_redir();

        // Redirect during a miss defers to DISCARD; late word is dropped
        Ihit = 0;
        tick();
        chk("m40_busy", {31'b0, FetchBusy}, 1);
        JumpD = 1; JumpTargetD = 32'h200;
        tick();
        chk("disc_pc", PCF, 32'h40);
        chk("disc_busy", {31'b0, FetchBusy}, 1);
        clr_redir(); Ihit = 1;
        #1;
        chk("disc_valid", {31'b0, ValidF}, 0);
        chk("disc_instr", InstrF, 0);
        tick();
        chk("disc_tgt", PCF, 32'h200);
        chk("disc_run", {31'b0, FetchBusy}, 0);
        chk("disc_cnt", {16'b0, MissCount}, 2);

        // Latest redirect wins while discarding
        Ihit = 0;
        tick();
        JumpD = 1; JumpTargetD = 32'h500;
        tick();
        clr_redir(); PCSrcD = 1; BranchTargetD = 32'h600;
        tick();
        clr_redir(); Ihit = 1;
        tick();
        chk("latest_pc", PCF, 32'h600);
        chk("latest_cnt", {16'b0, MissCount}, 3);

        // Jump-register outranks branch
        JumpRegD = 1; JumpRegTargetD = 32'h300; PCSrcD = 1; BranchTargetD = 32'h400;
        tick();
        chk("prio_pc", PCF, 32'h300);
        clr_redir();

        // Redirect coinciding with the fill in MISS
        Ihit = 0;
        tick();
        JumpD = 1; JumpTargetD = 32'h700; Ihit = 1;
        #1;
        chk("mhit_valid", {31'b0, ValidF}, 0);
        tick();
        chk("mhit_pc", PCF, 32'h700);
        chk("mhit_busy", {31'b0, FetchBusy}, 0);

        // Redirect on a RUN miss abandons it uncounted
        JumpTargetD = 32'h800; Ihit = 0;
        tick();
        chk("abandon_pc", PCF, 32'h800);
        chk("abandon_busy", {31'b0, FetchBusy}, 0);
        chk("abandon_cnt", {16'b0, MissCount}, 4);

        // PC+4 wraps at the top of the address space
        JumpTargetD = 32'hFFFF_FFFC; Ihit = 1;
        tick();
        clr_redir();
        #1;
        chk("wrap_plus4", PCPlus4F, 32'h0);
        tick();
        chk("wrap_pc", PCF, 32'h0);

        // Reset while discarding with a pending redirect
        Ihit = 0;
        tick();
        JumpD = 1; JumpTargetD = 32'hABC0;
        tick();
        chk("pre_rst_busy", {31'b0, FetchBusy}, 1);
        reset = 1;
        #1;
        chk("inrst_busy", {31'b0, FetchBusy}, 0);
        chk("inrst_req", {31'b0, imem_req}, 0);
        tick();
        chk("post_rst_pc", PCF, 32'h0);
        chk("post_rst_cnt", {16'b0, MissCount}, 0);
        reset = 0; clr_redir(); Ihit = 1;
        #1;
        chk("post_rst_busy", {31'b0, FetchBusy}, 0);
        chk("post_rst_valid", {31'b0, ValidF}, 1);
        tick();
        chk("post_rst_step", PCF, 32'h4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
